sha_round_ctrl: RTL

SHA_ROUND_CTRL -- requirements
Module: sha_round_ctrl

---
 rtl/sha_round_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/sha_round_ctrl.sv
// SHA-256 block compression sequencer.
// Walks one 512-bit block through INIT (load working variables, optionally
// seed H0..H7), ROUNDS compression rounds, the hash-register update and a
// one-cycle done pulse. Every output is decoded from the registered state and
// round counter, so nothing combinational runs from the inputs to the outputs.
module sha_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_first_block,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_init_h,
  output logic             o_load_wv,
  output logic             o_round_en,
  output logic [IDX_W-1:0] o_round_idx,
  output logic             o_msg_sel,
  output logic             o_hash_upd,
  output logic             o_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_ROUND  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Last round index, and the number of rounds fed directly from message words.
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] MSG_WORDS = IDX_W'(16);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  // State, round counter and first-block flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (state_q != S_IDLE && i_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          // An abort arriving with the start request cancels it outright.
          if (i_start && !i_abort) begin
            state_d = S_INIT;
            first_d = i_first_block;
          end
        end
        S_INIT: begin
          cnt_d   = '0;
          state_d = S_ROUND;
        end
        S_ROUND: begin
          // Counter parks on the last index rather than wrapping to zero.
          if (cnt_q == LAST_IDX) begin
            state_d = S_UPDATE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
        S_UPDATE: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state and counter only.
  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_load_wv   = (state_q == S_INIT);
    o_init_h    = (state_q == S_INIT) && first_q;
    o_round_en  = (state_q == S_ROUND);
    o_round_idx = (state_q == S_ROUND) ? cnt_q : '0;
    o_msg_sel   = (state_q == S_ROUND) && (cnt_q < MSG_WORDS);
    o_hash_upd  = (state_q == S_UPDATE);
    o_done      = (state_q == S_DONE);
  end

endmodule
